div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Iterative radix-2 restoring divider for RV32-M DIV/DIVU/REM/REMU.
//  Responder side of the M-extension start/done handshake: the EX-stage M wrapper pulses i_start
//  and stalls until o_done. One division at a time, XLEN iterations, result held until next start.
// PARAMETERS
//  XLEN      32   operand/result width (default from `XLEN)
//  CNT_W     $clog2(XLEN)+1   iteration counter width (derived, not overridden)
// PORTS
//  i_clk     in   1     clock; all state on posedge
//  i_rst     in   1     reset, synchronous, active-low
//  i_start   in   1     1-cycle request pulse; operands/i_f3 sampled this cycle
//  i_f3      in   3     funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU (i_f3[2]=1 always)
//  i_rs1     in   XLEN  dividend
//  i_rs2     in   XLEN  divisor
//  o_res     out  XLEN  quotient (f3[1]=0) or remainder (f3[1]=1); stable while o_done=1
//  o_done    out  1     result valid; level, held until next accepted i_start
// BEHAVIOUR
//  - Reset (i_rst=0 at posedge): state IDLE, o_done=0, o_res=0, counter=0; aborts any op in flight.
//  - FSM: IDLE -> CALC on i_start; CALC -> FIX after XLEN steps; FIX -> DONE; DONE -> CALC on i_start.
//  - i_start accepted in IDLE or DONE only; ignored in CALC/FIX (no restart, no corruption).
//  - Accept cycle: latch signed = ~f3[0], sel_rem = f3[1], sign_q = signed&(rs1[XLEN-1]^rs2[XLEN-1]),
//    sign_r = signed&rs1[XLEN-1]; latch |rs1|,|rs2| (abs only if signed); rem=0, cnt=0.
//    o_done drops to 0 on the cycle after acceptance.
//  - CALC step: {rem,quo} <<= 1; trial = rem - divisor (XLEN+1 bits); if trial>=0 {rem=trial, quo[0]=1}.
//  - FIX: negate quo if sign_q, negate rem if sign_r; select per sel_rem; register into o_res.
//  - Latency: i_start at cycle 0 -> o_done=1 at cycle XLEN+2 (34 for XLEN=32); o_res valid same cycle.
//  - Div by zero (rs2=0): quotient = all ones (-1), remainder = rs1 — falls out of algorithm with
//    sign fixes suppressed (sign_q forced 0 when rs2=0); must match spec for DIV and DIVU.
//  - Signed overflow (rs1=0x8000_0000, rs2=-1, DIV/REM): quotient 0x8000_0000, remainder 0.
//    |0x8000_0000| handled as XLEN+1-bit unsigned magnitude; no special case needed.
//  - o_res/o_done only change on acceptance, FIX->DONE, or reset.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in accept cycle, rs2=0, signed overflow, or |rs1|<|rs2| skip CALC;
//    result (per rules above) registered directly, o_done=1 at cycle 2. Other cases unchanged.
//  Undefined: every op takes exactly XLEN+2 cycles (fixed latency, formal-friendly).
// STRUCTURE
//  - div_pkg: state enum {IDLE,CALC,FIX,DONE}; funct3 constants F3_DIV/DIVU/REM/REMU;
//    helper function abs_mag(signed_en, x) returning XLEN+1-bit magnitude.
//  - Sub-module div_step: combinational single restoring iteration
//    (in rem, quo, divisor -> out rem, quo); instanced once in CALC datapath.
// TESTING
//  1 DIVU 100/7 -> o_res=14 at cycle 34; REMU 100/7 -> 2; o_done low cycles 1..33.
//  2 DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
//  3 DIVU 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5; DIV -5/0 -> 0xFFFF_FFFF.
//  4 DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM same -> 0.
//  5 i_start again at cycle 10 of op -> ignored, first result correct at 34; i_rst=0 at cycle 15
//    -> o_done=0, o_res=0 next cycle, new start then completes normally.
//  6 back-to-back: start at cycle 34 while o_done=1 -> o_done=0 at 35, second result at 68;
//    with DIV_EARLY_OUT_EN, DIVU 3/9 -> o_res=0, o_done=1 at cycle 2.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared constants and helpers for the iterative RV32-M divider.
//   DIV_XLEN     operand width, taken from `XLEN when the build defines it (default 32)
//   ST_*         divider FSM state encodings (IDLE, CALC, FIX, DONE)
//   F3_*         M-extension funct3 codes handled by the divider
//   abs_mag()    XLEN+1-bit magnitude of an operand, two's-complement abs when signed
`ifndef XLEN
`define XLEN 32
`endif

package div_pkg;

  localparam int unsigned DIV_XLEN = `XLEN;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Magnitude of the most negative value is 2^(XLEN-1), which the XLEN-bit
  // negation already yields as an unsigned pattern; the extra MSB keeps it unambiguous.
  function automatic logic [DIV_XLEN:0] abs_mag(input logic signed_en,
                                                input logic [DIV_XLEN-1:0] x);
    if (signed_en && x[DIV_XLEN-1]) begin
      abs_mag = {1'b0, ~x + DIV_XLEN'(1)};
    end else begin
      abs_mag = {1'b0, x};
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem        current partial remainder (XLEN+1 bits)
//   quo        dividend/quotient shift register (XLEN bits)
//   dvs        divisor magnitude (XLEN+1 bits)
//   rem_nxt_c  partial remainder after this iteration
//   quo_nxt_c  shift register after this iteration (new quotient bit in LSB)
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN:0]   dvs,
  output logic [XLEN:0]   rem_nxt_c,
  output logic [XLEN-1:0] quo_nxt_c
);

  logic [XLEN+1:0] sh_c;
  logic [XLEN+1:0] trial_c;

  // Shift next dividend bit into the remainder, subtract, restore on borrow.
  always_comb begin
    sh_c      = {rem, quo[XLEN-1]};
    trial_c   = sh_c - {1'b0, dvs};
    rem_nxt_c = sh_c[XLEN:0];
    quo_nxt_c = {quo[XLEN-2:0], 1'b0};
    if (!trial_c[XLEN+1]) begin
      rem_nxt_c    = trial_c[XLEN:0];
      quo_nxt_c[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for RV32-M DIV/DIVU/REM/REMU.
// Responder of the M-extension start/done handshake; one division at a time.
//   i_clk    clock, all state on posedge
//   i_rst    synchronous active-low reset
//   i_start  one-cycle request; i_f3/i_rs1/i_rs2 sampled the same cycle
//   i_f3     funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   i_rs1    dividend
//   i_rs2    divisor
//   o_res    quotient or remainder, stable while o_done=1
//   o_done   result valid level, held until the next accepted i_start
// Build option: DIV_EARLY_OUT_EN skips the iterations for divide-by-zero,
// signed overflow and |rs1|<|rs2| (o_done two cycles after the start).
// Without it every operation takes exactly XLEN+2 cycles.
// XLEN must match the package width (set through `XLEN).
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_res,
  output logic            o_done
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN:0]   rem;
  logic [XLEN:0]   dvs;
  logic            sign_q;
  logic            sign_r;
  logic            sel_rem;

  logic            accept_c;
  logic            signed_c;
  logic            early_c;
  logic [XLEN:0]   mag_a_c;
  logic [XLEN:0]   mag_b_c;
  logic [XLEN-1:0] early_quo_c;
  logic [XLEN:0]   early_rem_c;
  logic [XLEN:0]   step_rem_c;
  logic [XLEN-1:0] step_quo_c;
  logic [XLEN-1:0] res_fix_c;
  logic            unused_ok;

  assign accept_c = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign signed_c = ~i_f3[0];
  assign mag_a_c  = abs_mag(signed_c, i_rs1);
  assign mag_b_c  = abs_mag(signed_c, i_rs2);
  // funct3[2] is always set for this unit; dividend magnitude never needs its MSB
  assign unused_ok = ^{i_f3[2], mag_a_c[XLEN]};

`ifdef DIV_EARLY_OUT_EN
  logic rs2_zero_c;
  logic ovf_c;

  assign rs2_zero_c = (i_rs2 == '0);
  assign ovf_c      = signed_c && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
  assign early_c    = rs2_zero_c || ovf_c || (mag_a_c < mag_b_c);

  // Magnitude results the iterations would have produced; FIX applies signs as usual.
  always_comb begin
    early_quo_c = '0;
    early_rem_c = mag_a_c;
    if (rs2_zero_c) begin
      early_quo_c = '1;
    end else if (ovf_c) begin
      early_quo_c = mag_a_c[XLEN-1:0];
      early_rem_c = '0;
    end
  end
`else
  assign early_c     = 1'b0;
  assign early_quo_c = '0;
  assign early_rem_c = '0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem       (rem),
    .quo       (quo),
    .dvs       (dvs),
    .rem_nxt_c (step_rem_c),
    .quo_nxt_c (step_quo_c)
  );

  // Sign correction and result select for the FIX cycle.
  always_comb begin
    res_fix_c = sign_q ? -quo : quo;
    if (sel_rem) begin
      res_fix_c = sign_r ? XLEN'(-rem) : XLEN'(rem);
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (accept_c) state_nxt = early_c ? ST_FIX : ST_CALC;
      ST_CALC:          if (cnt == CNT_W'(XLEN - 1)) state_nxt = ST_FIX;
      ST_FIX:           state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      sel_rem <= 1'b0;
      o_res   <= '0;
      o_done  <= 1'b0;
    end else if (accept_c) begin
      sel_rem <= i_f3[1];
      // Divide-by-zero quotient is all ones regardless of operand signs.
      sign_q  <= signed_c & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]) & (i_rs2 != '0);
      sign_r  <= signed_c & i_rs1[XLEN-1];
      dvs     <= mag_b_c;
      cnt     <= '0;
      o_done  <= 1'b0;
      if (early_c) begin
        quo <= early_quo_c;
        rem <= early_rem_c;
      end else begin
        quo <= mag_a_c[XLEN-1:0];
        rem <= '0;
      end
    end else if (state == ST_CALC) begin
      quo <= step_quo_c;
      rem <= step_rem_c;
      cnt <= cnt + CNT_W'(1);
    end else if (state == ST_FIX) begin
      o_res  <= res_fix_c;
      o_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed scoreboard bench for div_seq (XLEN=32).
// Driver pushes expected result and completion cycle; a negedge monitor pops
// on each rising o_done and compares value and timing.
`timescale 1ns/1ps
module tb_div_seq;
  import div_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_f3;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] o_res;
  logic        o_done;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic done_q = 1'b0;

  div_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_f3    (i_f3),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .o_res   (o_res),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic int lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 2 : 34;
`else
    return 34;
`endif
  endfunction

  // Monitor: compare on each rising edge of o_done.
  always @(negedge i_clk) begin
    if (o_done && !done_q) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL spurious_done: o_res=%h with no operation pending (cycle %0d)", o_res, cyc);
      end else begin
        mon_e  = sb.pop_front();
        checks = checks + 2;
        if (o_res !== mon_e.res) begin
          errors = errors + 1;
          $display("FAIL %s value: got %h want %h", mon_e.name, o_res, mon_e.res);
        end
        if (cyc != mon_e.due) begin
          errors = errors + 1;
          $display("FAIL %s latency: done at cycle %0d want %0d", mon_e.name, cyc, mon_e.due);
        end
      end
    end
    done_q = o_done;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Pulse i_start for one cycle (called at a negedge) and record the expectation.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit early, input string name);
    exp_t e;
    e.res  = exp_res;
    e.due  = cyc + lat(early);
    e.name = name;
    sb.push_back(e);
    i_f3    = f3;
    i_rs1   = a;
    i_rs2   = b;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: %0d result(s) pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input bit early, input string name);
    issue(f3, a, b, exp_res, early, name);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_f3    = F3_DIVU;
    i_rs1   = '0;
    i_rs2   = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    chk("reset_res", o_res, 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Unsigned and signed basics
    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
    run(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
    run(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    run(F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, "rem_7_m2");
    run(F3_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7");
    run(F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, "rem_m100_7");
    run(F3_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, "div_min_2");
    run(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "divu_max_1");
    run(F3_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b0, "remu_max_16");

    // Divide by zero, signed overflow, small dividend
    run(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "divu_5_0");
    run(F3_REM, 32'd5, 32'd0, 32'd5, 1'b1, "rem_5_0");
    run(F3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_m5_0");
    run(F3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, "rem_m5_0");
    run(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    run(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rem_ovf");
    run(F3_DIVU, 32'd3, 32'd9, 32'd0, 1'b1, "divu_3_9");
    run(F3_REM, 32'd3, 32'hFFFF_FFF7, 32'd3, 1'b1, "rem_3_m9");

    // Start during CALC is ignored; operands changed under it must not matter
    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu_restart_ignored");
    repeat (9) @(negedge i_clk);
    i_f3    = F3_REMU;
    i_rs1   = 32'd9;
    i_rs2   = 32'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_idle();

    // Reset mid-operation aborts it and clears outputs
    issue(F3_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, "divu_aborted");
    repeat (14) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    sb.delete();
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_res", o_res, 32'd0);
    repeat (40) @(negedge i_clk);
    chk("abort_stays_idle", {31'd0, o_done}, 32'd0);
    run(F3_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, "divu_after_reset");

    // Back-to-back: second start in the first cycle o_done is high
    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "b2b_first");
    repeat (33) @(negedge i_clk);
    chk("b2b_done_high", {31'd0, o_done}, 32'd1);
    issue(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "b2b_second");
    chk("b2b_done_drop", {31'd0, o_done}, 32'd0);
    chk("b2b_res_held", o_res, 32'd14);
    wait_idle();
    chk("final_res_held", o_res, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
